pipe_instr_tracker: RTL and testbench
=====================================

PIPE_INSTR_TRACKER -- requirements
Module: pipe_instr_tracker

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), the word loaded into a stage on flush or reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port instr_F  input  32  fetched instruction offered to the D stage.
REQ-005 SHALL have port pc_F  input  32  PC of instr_F.
REQ-006 SHALL have ports IF_ID_enable, ID_EX_enable, EX_ME_enable, ME_WB_enable  input  1 each  per-register load enable from hazard control.
REQ-007 SHALL have ports IF_ID_flush, ID_EX_flush, EX_ME_flush, ME_WB_flush  input  1 each  per-register bubble insert.
REQ-008 SHALL have port pc_enable  input  1  fetch advance; 0 = front-end stall.
REQ-009 SHALL have port cnt_clr  input  1  synchronous clear of all counters.
REQ-010 SHALL have ports instr_D, instr_E, instr_M, instr_W  output  32 each  instruction held in each stage register.
REQ-011 SHALL have ports valid_D, valid_E, valid_M, valid_W  output  1 each  stage holds a real (non-bubble) instruction.
REQ-012 SHALL have port pc_W  output  32  PC of instr_W.
REQ-013 SHALL have port retire  output  1  registered pulse: instr_W was newly loaded with a valid instruction this cycle.
REQ-014 SHALL have ports cycle_cnt, instret_cnt, stall_cnt, flush_cnt  output  32 each  performance counters.

Function
REQ-015 Each stage register X<-Y (D<-F, E<-D, M<-E, W<-M) SHALL update per edge: flush=1 -> instr=NOP_INSTR, valid=0, pc=0; else enable=1 -> copy instr/valid/pc from upstream; else hold.
REQ-016 Flush SHALL take priority over enable when both are 1 for the same register.
REQ-017 D-stage upstream valid SHALL be constant 1 (every fetched word is real).
REQ-018 Latency SHALL be 1 edge F->D and 4 edges F->W with all enables 1 and flushes 0.
REQ-019 A held stage SHALL keep instr, valid and pc unchanged while its downstream stage may load; the same instruction is then loaded downstream again only if upstream is held and downstream enabled — duplicates SHALL be prevented by valid: a stage loads valid=0 when the upstream stage's enable was 0 in the same cycle and its own flush=0 (bubble behind a stall).
REQ-020 retire SHALL be 1 on the cycle after an edge where ME_WB_enable=1, ME_WB_flush=0 and valid_M=1 and no bubble rule (REQ-019) applied; otherwise 0.
REQ-021 cycle_cnt SHALL increment by 1 every edge.
REQ-022 instret_cnt SHALL increment on each edge where retire-qualifying conditions of REQ-020 hold.
REQ-023 stall_cnt SHALL increment on each edge where pc_enable=0.
REQ-024 flush_cnt SHALL increment on each edge where IF_ID_flush=1.
REQ-025 All counters SHALL be 32-bit unsigned, wrapping 32'hFFFF_FFFF -> 0 without flag.
REQ-026 cnt_clr=1 SHALL set all counters to 0 on that edge, overriding any simultaneous increment; pipeline registers unaffected.
REQ-027 Block SHALL contain no combinational path from any input to any output.

Reset
REQ-028 While rst=1 all instr_* SHALL be NOP_INSTR, all valid_* 0, pc_W 0, retire 0, all counters 0, asynchronously.
REQ-029 Deassertion of rst SHALL resume normal operation on the first following rising edge; rst asserted mid-stall or mid-flush SHALL discard all in-flight state.

Verification
REQ-030 Streaming: reset, all enables 1, instr_F = 32'h0010_0093, 32'h0020_0113, ... each cycle -> instr_W=32'h0010_0093, pc_W=pc of that word, retire=1 on cycle 4 after reset release; instret_cnt=1 then.
REQ-031 Stall: hold IF_ID/ID_EX enable=0, ID_EX_flush=1, pc_enable=0 for 2 cycles -> instr_D held, instr_E=NOP_INSTR valid_E=0, stall_cnt=2, no duplicate retire.
REQ-032 Branch flush: IF_ID_flush=1 and ID_EX_flush=1 one cycle -> instr_D=instr_E=NOP_INSTR, valids 0, flush_cnt=1, older M/W instructions retire normally.
REQ-033 Priority: ID_EX_enable=1 and ID_EX_flush=1 together -> instr_E=NOP_INSTR, valid_E=0.
REQ-034 Counter edge: force cycle_cnt near 32'hFFFF_FFFF (run or backdoor) -> wraps to 0; cnt_clr=1 on same edge as increments -> all counters 0 next cycle.
REQ-035 Async reset: assert rst between edges during active stream -> outputs return to reset values immediately without clock edge.

Source files
------------

// File: rtl/pipe_instr_tracker.sv
// Four-register pipeline tracker (D/E/M/W) with per-register enable/flush, bubble
// marking behind stalls, retire pulse and wrapping performance counters.
module pipe_instr_tracker #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_F,
  input  logic [31:0] pc_F,
  input  logic        IF_ID_enable,
  input  logic        ID_EX_enable,
  input  logic        EX_ME_enable,
  input  logic        ME_WB_enable,
  input  logic        IF_ID_flush,
  input  logic        ID_EX_flush,
  input  logic        EX_ME_flush,
  input  logic        ME_WB_flush,
  input  logic        pc_enable,
  input  logic        cnt_clr,
  output logic [31:0] instr_D,
  output logic [31:0] instr_E,
  output logic [31:0] instr_M,
  output logic [31:0] instr_W,
  output logic        valid_D,
  output logic        valid_E,
  output logic        valid_M,
  output logic        valid_W,
  output logic [31:0] pc_W,
  output logic        retire,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  // Index 0..3 = D, E, M, W stage registers.
  logic [31:0] instr_q [4];
  logic [31:0] pc_q    [4];
  logic        valid_q [4];

  logic [31:0] up_instr [4];
  logic [31:0] up_pc    [4];
  logic        up_valid [4];

  logic [3:0]  en;
  logic [3:0]  fl;
  logic [3:0]  up_en;
  logic        retire_d;
  logic        retire_q;

  logic [31:0] cycle_q;
  logic [31:0] instret_q;
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  assign en    = {ME_WB_enable, EX_ME_enable, ID_EX_enable, IF_ID_enable};
  assign fl    = {ME_WB_flush, EX_ME_flush, ID_EX_flush, IF_ID_flush};
  // The fetch stage's own "enable" is pc_enable.
  assign up_en = {en[2:0], pc_enable};

  always_comb begin
    up_instr[0] = instr_F;
    up_pc[0]    = pc_F;
    up_valid[0] = 1'b1;
    for (int i = 1; i < 4; i++) begin
      up_instr[i] = instr_q[i-1];
      up_pc[i]    = pc_q[i-1];
      up_valid[i] = valid_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        instr_q[i] <= NOP_INSTR;
        pc_q[i]    <= 32'h0;
        valid_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (fl[i]) begin
          instr_q[i] <= NOP_INSTR;
          pc_q[i]    <= 32'h0;
          valid_q[i] <= 1'b0;
        end else if (en[i]) begin
          instr_q[i] <= up_instr[i];
          pc_q[i]    <= up_pc[i];
          // A held upstream stage would otherwise be copied twice.
          valid_q[i] <= up_valid[i] & up_en[i];
        end
      end
    end
  end

  assign retire_d = ME_WB_enable & ~ME_WB_flush & valid_q[2] & EX_ME_enable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_q <= 1'b0;
    end else begin
      retire_q <= retire_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= 32'h0;
      instret_q <= 32'h0;
      stall_q   <= 32'h0;
      flush_q   <= 32'h0;
    end else if (cnt_clr) begin
      cycle_q   <= 32'h0;
      instret_q <= 32'h0;
      stall_q   <= 32'h0;
      flush_q   <= 32'h0;
    end else begin
      cycle_q   <= cycle_q + 32'd1;
      instret_q <= instret_q + {31'h0, retire_d};
      stall_q   <= stall_q + {31'h0, ~pc_enable};
      flush_q   <= flush_q + {31'h0, IF_ID_flush};
    end
  end

  assign instr_D     = instr_q[0];
  assign instr_E     = instr_q[1];
  assign instr_M     = instr_q[2];
  assign instr_W     = instr_q[3];
  assign valid_D     = valid_q[0];
  assign valid_E     = valid_q[1];
  assign valid_M     = valid_q[2];
  assign valid_W     = valid_q[3];
  assign pc_W        = pc_q[3];
  assign retire      = retire_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipe_instr_tracker.sv
// Bench for pipe_instr_tracker: directed scenarios plus random hazard traffic, checked
// every cycle against a stage-list model of the pipeline.
module tb_pipe_instr_tracker;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_F, pc_F;
  logic        IF_ID_enable, ID_EX_enable, EX_ME_enable, ME_WB_enable;
  logic        IF_ID_flush, ID_EX_flush, EX_ME_flush, ME_WB_flush;
  logic        pc_enable, cnt_clr;
  logic [31:0] instr_D, instr_E, instr_M, instr_W, pc_W;
  logic        valid_D, valid_E, valid_M, valid_W, retire;
  logic [31:0] cycle_cnt, instret_cnt, stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_instr_tracker #(.NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .instr_F(instr_F), .pc_F(pc_F),
    .IF_ID_enable(IF_ID_enable), .ID_EX_enable(ID_EX_enable),
    .EX_ME_enable(EX_ME_enable), .ME_WB_enable(ME_WB_enable),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .EX_ME_flush(EX_ME_flush), .ME_WB_flush(ME_WB_flush),
    .pc_enable(pc_enable), .cnt_clr(cnt_clr),
    .instr_D(instr_D), .instr_E(instr_E), .instr_M(instr_M), .instr_W(instr_W),
    .valid_D(valid_D), .valid_E(valid_E), .valid_M(valid_M), .valid_W(valid_W),
    .pc_W(pc_W), .retire(retire),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Model: one entry per stage, D=0 .. W=3.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } slot_t;

  slot_t       m_stage [4];
  logic        m_retire;
  int unsigned m_cycle, m_instret, m_stall, m_flush;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_stage[i] = '{instr: NOP, pc: 32'h0, valid: 1'b0};
    m_retire = 1'b0;
    m_cycle = 0; m_instret = 0; m_stall = 0; m_flush = 0;
  endtask

  // Apply one clock edge's worth of pipeline rules to the model.
  task automatic model_edge();
    slot_t old [4];
    slot_t up;
    logic [3:0] en, fl, upen;
    logic ret;
    if (rst) begin
      model_reset();
      return;
    end
    en   = {ME_WB_enable, EX_ME_enable, ID_EX_enable, IF_ID_enable};
    fl   = {ME_WB_flush, EX_ME_flush, ID_EX_flush, IF_ID_flush};
    upen = {EX_ME_enable, ID_EX_enable, IF_ID_enable, pc_enable};
    old  = m_stage;
    for (int i = 0; i < 4; i++) begin
      up = (i == 0) ? '{instr: instr_F, pc: pc_F, valid: 1'b1} : old[i-1];
      if (fl[i]) m_stage[i] = '{instr: NOP, pc: 32'h0, valid: 1'b0};
      else if (en[i]) m_stage[i] = '{instr: up.instr, pc: up.pc, valid: up.valid && upen[i]};
    end
    ret = ME_WB_enable && !ME_WB_flush && old[2].valid && EX_ME_enable;
    m_retire = ret;
    if (cnt_clr) begin
      m_cycle = 0; m_instret = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_cycle++;
      if (ret) m_instret++;
      if (!pc_enable) m_stall++;
      if (IF_ID_flush) m_flush++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("instr_D", instr_D, m_stage[0].instr);
    chk("instr_E", instr_E, m_stage[1].instr);
    chk("instr_M", instr_M, m_stage[2].instr);
    chk("instr_W", instr_W, m_stage[3].instr);
    chk("valid_D", {31'h0, valid_D}, {31'h0, m_stage[0].valid});
    chk("valid_E", {31'h0, valid_E}, {31'h0, m_stage[1].valid});
    chk("valid_M", {31'h0, valid_M}, {31'h0, m_stage[2].valid});
    chk("valid_W", {31'h0, valid_W}, {31'h0, m_stage[3].valid});
    chk("pc_W", pc_W, m_stage[3].pc);
    chk("retire", {31'h0, retire}, {31'h0, m_retire});
    chk("cycle_cnt", cycle_cnt, m_cycle);
    chk("instret_cnt", instret_cnt, m_instret);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic run_all();
    {IF_ID_enable, ID_EX_enable, EX_ME_enable, ME_WB_enable, pc_enable} = 5'h1f;
    {IF_ID_flush, ID_EX_flush, EX_ME_flush, ME_WB_flush, cnt_clr} = 5'h0;
  endtask

  logic [31:0] word, held_d;

  initial begin
    rst = 1'b1;
    instr_F = 32'h0; pc_F = 32'h0;
    run_all();
    model_reset();
    @(negedge clk);
    compare();
    chk("reset_instr_W", instr_W, NOP);
    @(negedge clk);
    rst = 1'b0;

    // Streaming: first word reaches W after four edges.
    word = 32'h0010_0093;
    for (int k = 0; k < 8; k++) begin
      instr_F = word;
      pc_F    = 32'h1000 + 32'(k) * 4;
      word    = word + 32'h0010_0080;
      tick();
      if (k == 3) begin
        chk("stream_instr_W", instr_W, 32'h0010_0093);
        chk("stream_pc_W", pc_W, 32'h0000_1000);
        chk("stream_retire", {31'h0, retire}, 32'h1);
        chk("stream_instret", instret_cnt, 32'h1);
      end
    end

    // Stall with bubble into E.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    held_d = instr_D;
    IF_ID_enable = 1'b0; ID_EX_enable = 1'b0; ID_EX_flush = 1'b1; pc_enable = 1'b0;
    for (int k = 0; k < 2; k++) begin
      instr_F = $urandom; pc_F = $urandom;
      tick();
    end
    chk("stall_instr_D", instr_D, m_stage[0].instr);
    chk("stall_instr_E", instr_E, NOP);
    chk("stall_valid_E", {31'h0, valid_E}, 32'h0);
    chk("stall_cnt_2", stall_cnt, 32'h2);
    chk("stall_d_held", {31'h0, instr_D == held_d}, 32'h1);
    run_all();

    // Branch flush of D and E.
    cnt_clr = 1'b1;
    tick();
    run_all();
    IF_ID_flush = 1'b1; ID_EX_flush = 1'b1;
    tick();
    chk("flush_instr_D", instr_D, NOP);
    chk("flush_valid_D", {31'h0, valid_D}, 32'h0);
    chk("flush_valid_E", {31'h0, valid_E}, 32'h0);
    chk("flush_cnt_1", flush_cnt, 32'h1);
    run_all();

    // Flush beats enable on the same register.
    tick();
    ID_EX_flush = 1'b1;
    tick();
    chk("prio_instr_E", instr_E, NOP);
    chk("prio_valid_E", {31'h0, valid_E}, 32'h0);
    run_all();

    // Counter wrap via backdoor preset, then clear overriding increments.
    dut.cycle_q = 32'hFFFF_FFFE;
    m_cycle = 32'hFFFF_FFFE;
    tick();
    tick();
    chk("wrap_cycle", cycle_cnt, 32'h0);
    pc_enable = 1'b0; IF_ID_flush = 1'b1; cnt_clr = 1'b1;
    tick();
    chk("clr_cycle", cycle_cnt, 32'h0);
    chk("clr_stall", stall_cnt, 32'h0);
    chk("clr_flush", flush_cnt, 32'h0);
    chk("clr_instret", instret_cnt, 32'h0);
    run_all();

    // Random hazard traffic.
    for (int k = 0; k < 400; k++) begin
      instr_F = $urandom; pc_F = $urandom;
      IF_ID_enable = ($urandom_range(9) < 8); ID_EX_enable = ($urandom_range(9) < 8);
      EX_ME_enable = ($urandom_range(9) < 8); ME_WB_enable = ($urandom_range(9) < 8);
      IF_ID_flush  = ($urandom_range(9) == 0); ID_EX_flush = ($urandom_range(9) == 0);
      EX_ME_flush  = ($urandom_range(9) == 0); ME_WB_flush = ($urandom_range(9) == 0);
      pc_enable    = ($urandom_range(9) < 8);
      cnt_clr      = ($urandom_range(49) == 0);
      tick();
    end

    // Asynchronous reset mid-stream, between edges.
    run_all();
    for (int k = 0; k < 5; k++) begin
      instr_F = $urandom; pc_F = $urandom;
      tick();
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare();
    chk("async_valid_W", {31'h0, valid_W}, 32'h0);
    chk("async_cycle", cycle_cnt, 32'h0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      instr_F = $urandom; pc_F = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
